// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial link inputs and recovered-frame outputs of the TDM
// receive demultiplexer. The link side (master) drives din/din_valid/frame_sync;
// the demux (slave) drives the recovered frame, slot index and status pulses.
// Optional macro TDM_DEMUX_PARITY_EN widens sel to 4 bits and adds parity_err.
interface tdm_demux_if;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SEL_W = 4;
`else
  localparam int SEL_W = 3;
`endif

  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [7:0]       out;
  logic             frame_valid;
  logic [SEL_W-1:0] sel;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_err;

  modport master (output din, din_valid, frame_sync,
                  input  out, frame_valid, sel, locked, sync_err, parity_err);
  modport slave  (input  din, din_valid, frame_sync,
                  output out, frame_valid, sel, locked, sync_err, parity_err);
`else
  modport master (output din, din_valid, frame_sync,
                  input  out, frame_valid, sel, locked, sync_err);
  modport slave  (input  din, din_valid, frame_sync,
                  output out, frame_valid, sel, locked, sync_err);
`endif
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the 8-channel TDM link. Hunts for frame_sync,
// tracks the slot index, accumulates one frame and publishes it as a
// registered 8-bit word with a one-cycle frame_valid pulse. A flywheel keeps
// lock across up to SYNC_LOSS_LIMIT-1 missing sync markers.
// Optional macro TDM_DEMUX_PARITY_EN: 9-slot frame, slot 8 carries even
// parity over slots 0..7; a parity mismatch holds out and pulses parity_err.
module tdm_demux #(
  parameter int SYNC_LOSS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SEL_W = 4;
  localparam int STG_W = 8;
  localparam logic [SEL_W-1:0] LAST_SLOT = 4'd8;
`else
  localparam int SEL_W = 3;
  localparam int STG_W = 7;   // slot 7 goes straight to out, never staged
  localparam logic [SEL_W-1:0] LAST_SLOT = 3'd7;
`endif
  localparam logic [SEL_W-1:0] SLOT0 = '0;
  localparam logic [SEL_W-1:0] SLOT1 = SEL_W'(1);
  localparam logic [1:0]       LOSS_LIMIT = 2'(SYNC_LOSS_LIMIT);

  typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;

`ifdef TDM_DEMUX_PARITY_EN
  // Even parity bit expected for a data byte.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  state_t             state_r, state_nxt_s;
  logic [SEL_W-1:0]   sel_r, sel_nxt_s;
  logic [STG_W-1:0]   staging_r, staging_nxt_s;
  logic [1:0]         miss_r, miss_nxt_s, miss_inc_s;
  logic [7:0]         out_r, out_nxt_s;
  logic               frame_valid_r, frame_valid_nxt_s;
  logic               sync_err_r, sync_err_nxt_s;
  logic               locked_r;
`ifdef TDM_DEMUX_PARITY_EN
  logic               parity_err_r, parity_err_nxt_s;
`endif

  // Next-state and output decode for each accepted serial bit.
  always_comb begin
    state_nxt_s       = state_r;
    sel_nxt_s         = sel_r;
    staging_nxt_s     = staging_r;
    miss_nxt_s        = miss_r;
    out_nxt_s         = out_r;
    frame_valid_nxt_s = 1'b0;
    sync_err_nxt_s    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_nxt_s  = 1'b0;
`endif
    miss_inc_s        = miss_r + 2'd1;
    if (bus.din_valid) begin
      case (state_r)
        HUNT: begin
          if (bus.frame_sync) begin
            staging_nxt_s = {{(STG_W-1){1'b0}}, bus.din};
            sel_nxt_s     = SLOT1;
            miss_nxt_s    = 2'd0;
            state_nxt_s   = LOCKED;
          end else begin
            sel_nxt_s     = SLOT0;
          end
        end
        LOCKED: begin
          if (sel_r == SLOT0) begin
            if (bus.frame_sync) begin
              miss_nxt_s       = 2'd0;
              staging_nxt_s[0] = bus.din;
              sel_nxt_s        = SLOT1;
            end else if (miss_inc_s >= LOSS_LIMIT) begin
              // Too many missing markers: drop the bit and re-hunt.
              miss_nxt_s  = 2'd0;
              sel_nxt_s   = SLOT0;
              state_nxt_s = HUNT;
            end else begin
              // Flywheel: assume the frame boundary is still correct.
              miss_nxt_s       = miss_inc_s;
              staging_nxt_s[0] = bus.din;
              sel_nxt_s        = SLOT1;
            end
          end else if (bus.frame_sync) begin
            // Misplaced marker: abandon the partial frame, restart at slot 0.
            sync_err_nxt_s = 1'b1;
            staging_nxt_s  = {{(STG_W-1){1'b0}}, bus.din};
            miss_nxt_s     = 2'd0;
            sel_nxt_s      = SLOT1;
          end else if (sel_r == LAST_SLOT) begin
`ifdef TDM_DEMUX_PARITY_EN
            if (even_parity(staging_r) == bus.din) begin
              out_nxt_s         = staging_r;
              frame_valid_nxt_s = 1'b1;
            end else begin
              parity_err_nxt_s  = 1'b1;
            end
`else
            out_nxt_s         = {bus.din, staging_r};
            frame_valid_nxt_s = 1'b1;
`endif
            sel_nxt_s = SLOT0;
          end else begin
            staging_nxt_s[sel_r[2:0]] = bus.din;
            sel_nxt_s                 = sel_r + SLOT1;
          end
        end
        default: begin
          state_nxt_s = HUNT;
          sel_nxt_s   = SLOT0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= HUNT;
      sel_r         <= SLOT0;
      staging_r     <= '0;
      miss_r        <= 2'd0;
      out_r         <= 8'h00;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      locked_r      <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_r  <= 1'b0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      sel_r         <= sel_nxt_s;
      staging_r     <= staging_nxt_s;
      miss_r        <= miss_nxt_s;
      out_r         <= out_nxt_s;
      frame_valid_r <= frame_valid_nxt_s;
      sync_err_r    <= sync_err_nxt_s;
      locked_r      <= (state_nxt_s == LOCKED);
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_r  <= parity_err_nxt_s;
`endif
    end
  end

  assign bus.out         = out_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.sel         = sel_r;
  assign bus.locked      = locked_r;
  assign bus.sync_err    = sync_err_r;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err  = parity_err_r;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed-vector bench for tdm_demux (SYNC_LOSS_LIMIT=2).
// Honours TDM_DEMUX_PARITY_EN: frames then carry an even-parity slot 8.
module tb_tdm_demux;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif
  localparam int LAST = FRAME_LEN - 1;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  tdm_demux_if bus();

  tdm_demux #(.SYNC_LOSS_LIMIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [7:0] d, input int s);
    if (s < 8) return d[s];
    else return ^d;
  endfunction

  task automatic send_bit(input logic d, input logic fs);
    @(negedge clk);
    bus.din        = d;
    bus.frame_sync = fs;
    bus.din_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Invalid cycle with junk on din/frame_sync; must be ignored.
  task automatic idle_cycle();
    @(negedge clk);
    bus.din_valid  = 1'b0;
    bus.din        = 1'b1;
    bus.frame_sync = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_slots(input logic [7:0] d, input int first, input int last,
                            input logic sync0, input logic gapped);
    for (int s = first; s <= last; s++) begin
      send_bit(slot_bit(d, s), (s == first) ? sync0 : 1'b0);
      check_val($sformatf("fv_%02h_s%0d", d, s), 8'(bus.frame_valid), 8'(s == LAST));
      check_val($sformatf("sel_%02h_s%0d", d, s), 8'(bus.sel), 8'((s + 1) % FRAME_LEN));
      check_val($sformatf("serr_%02h_s%0d", d, s), 8'(bus.sync_err), 8'h00);
      if (s == LAST) check_val($sformatf("out_%02h", d), bus.out, d);
      if (gapped) begin
        idle_cycle();
        check_val($sformatf("gapfv_%02h_s%0d", d, s), 8'(bus.frame_valid), 8'h00);
        check_val($sformatf("gapsel_%02h_s%0d", d, s), 8'(bus.sel), 8'((s + 1) % FRAME_LEN));
      end
    end
  endtask

  initial begin
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", bus.out, 8'h00);
    check_val("rst_fv", 8'(bus.frame_valid), 8'h00);
    check_val("rst_sel", 8'(bus.sel), 8'h00);
    check_val("rst_lock", 8'(bus.locked), 8'h00);
    check_val("rst_serr", 8'(bus.sync_err), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Hunting: bits without sync are discarded.
    send_bit(1'b1, 1'b0);
    check_val("hunt_sel", 8'(bus.sel), 8'h00);
    check_val("hunt_lock", 8'(bus.locked), 8'h00);

    // Lock on first sync bit, then A5 back-to-back.
    send_bit(1'b1, 1'b1);
    check_val("lock_first", 8'(bus.locked), 8'h01);
    check_val("lock_sel", 8'(bus.sel), 8'h01);
    send_slots(8'hA5, 1, LAST, 1'b0, 1'b0);
    idle_cycle();
    check_val("a5_pulse_end", 8'(bus.frame_valid), 8'h00);
    check_val("a5_hold", bus.out, 8'hA5);

    // Gapped din_valid.
    send_slots(8'h3C, 0, LAST, 1'b1, 1'b1);

    // Misplaced sync on the 4th bit of the third frame.
    send_slots(8'h11, 0, LAST, 1'b1, 1'b0);
    send_slots(8'h22, 0, LAST, 1'b1, 1'b0);
    send_slots(8'h33, 0, 2, 1'b1, 1'b0);
    send_bit(slot_bit(8'h5A, 0), 1'b1);
    check_val("mis_serr", 8'(bus.sync_err), 8'h01);
    check_val("mis_fv", 8'(bus.frame_valid), 8'h00);
    check_val("mis_out", bus.out, 8'h22);
    check_val("mis_sel", 8'(bus.sel), 8'h01);
    check_val("mis_lock", 8'(bus.locked), 8'h01);
    idle_cycle();
    check_val("mis_serr_end", 8'(bus.sync_err), 8'h00);
    send_slots(8'h5A, 1, LAST, 1'b0, 1'b0);

    // Misplaced sync at the last slot aborts that frame.
    send_slots(8'h44, 0, LAST - 1, 1'b1, 1'b0);
    send_bit(slot_bit(8'h69, 0), 1'b1);
    check_val("last_serr", 8'(bus.sync_err), 8'h01);
    check_val("last_fv", 8'(bus.frame_valid), 8'h00);
    check_val("last_out", bus.out, 8'h5A);
    send_slots(8'h69, 1, LAST, 1'b0, 1'b0);

    // Flywheel on first miss, lock loss on second, relock later.
    send_slots(8'h96, 0, LAST, 1'b0, 1'b0);
    check_val("fly_lock", 8'(bus.locked), 8'h01);
    send_bit(1'b1, 1'b0);
    check_val("loss_lock", 8'(bus.locked), 8'h00);
    check_val("loss_sel", 8'(bus.sel), 8'h00);
    check_val("loss_fv", 8'(bus.frame_valid), 8'h00);
    check_val("loss_out", bus.out, 8'h96);
    send_bit(1'b0, 1'b0);
    check_val("loss_sel2", 8'(bus.sel), 8'h00);
    send_slots(8'hC3, 0, LAST, 1'b1, 1'b0);
    check_val("relock", 8'(bus.locked), 8'h01);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity: out holds, parity_err pulses, lock unaffected.
    send_slots(8'hA5, 0, 7, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_val("par_err", 8'(bus.parity_err), 8'h01);
    check_val("par_fv", 8'(bus.frame_valid), 8'h00);
    check_val("par_out", bus.out, 8'hC3);
    check_val("par_lock", 8'(bus.locked), 8'h01);
    check_val("par_sel", 8'(bus.sel), 8'h00);
    idle_cycle();
    check_val("par_err_end", 8'(bus.parity_err), 8'h00);
    send_slots(8'hA5, 0, LAST, 1'b1, 1'b0);
`endif

    // Asynchronous reset in the middle of a frame (before slot 5).
    send_slots(8'h77, 0, 4, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mrst_out", bus.out, 8'h00);
    check_val("mrst_lock", 8'(bus.locked), 8'h00);
    check_val("mrst_sel", 8'(bus.sel), 8'h00);
    check_val("mrst_fv", 8'(bus.frame_valid), 8'h00);
    @(posedge clk);
    #1;
    check_val("mrst_fv2", 8'(bus.frame_valid), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1, 1'b0);
    check_val("post_rst_lock", 8'(bus.locked), 8'h00);
    send_slots(8'h81, 0, LAST, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
